// File: rtl/voice_mixer.sv
// Polyphonic voice mixer: per-voice gain MAC across N_VOICES snapshots, then master gain and range limit.
// Optional VOICE_MIXER_SATURATE_EN clamps the result (and drives clip_out); otherwise the result wraps.
module voice_mixer #(
   parameter int N_VOICES     = 8,
   parameter int SAMPLE_WIDTH = 24,
   parameter int VOL_WIDTH    = 8,
   parameter int VOL_SHIFT    = 7
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,
   input  logic                             valid_in,
   input  logic [N_VOICES*SAMPLE_WIDTH-1:0] voices_in,
   input  logic [N_VOICES*VOL_WIDTH-1:0]    vol_in,
   input  logic [N_VOICES-1:0]              active_in,
   input  logic [VOL_WIDTH-1:0]             master_vol_in,
   output logic [SAMPLE_WIDTH-1:0]          mix_out,
   output logic                             valid_out,
   output logic                             busy_out,
   output logic                             clip_out,
   output logic                             overrun_out
);
   localparam int PW = SAMPLE_WIDTH + VOL_WIDTH + 1;
   localparam int AW = SAMPLE_WIDTH + VOL_WIDTH + $clog2(N_VOICES) + 1;
   localparam int MW = AW + VOL_WIDTH + 1;
   localparam int IW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

   typedef enum logic [1:0] {IDLE, MAC, MASTER, OUT} state_t;

   state_t                   state_reg;
   logic signed [SAMPLE_WIDTH-1:0] voice_snap_reg [N_VOICES];
   logic [VOL_WIDTH-1:0]     vol_snap_reg [N_VOICES];
   logic [N_VOICES-1:0]      active_snap_reg;
   logic [VOL_WIDTH-1:0]     master_snap_reg;
   logic [IW-1:0]            mul_idx_reg;
   logic                     mul_on_reg;
   logic signed [PW-1:0]     prod_reg;
   logic                     prod_vld_reg;
   logic                     prod_act_reg;
   logic                     prod_last_reg;
   logic signed [AW-1:0]     acc_reg;
   logic [SAMPLE_WIDTH-1:0]  mix_reg;
   logic                     valid_reg;
   logic                     busy_reg;
   logic                     overrun_reg;
   logic                     capture;
   logic signed [PW-1:0]     prod_next;
   logic signed [AW-1:0]     term;
   logic signed [MW-1:0]     m_full;
   logic [SAMPLE_WIDTH-1:0]  out_val;
   logic                     out_clip;

   assign capture = (state_reg == IDLE) && valid_in;

   generate
      for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_snap
         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               voice_snap_reg[gi] <= '0;
               vol_snap_reg[gi]   <= '0;
            end else if (capture) begin
               voice_snap_reg[gi] <= voices_in[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
               vol_snap_reg[gi]   <= vol_in[gi*VOL_WIDTH +: VOL_WIDTH];
            end
         end
      end
   endgenerate

   // Gains are unsigned, so they get a zero sign bit before the signed multiply.
   assign prod_next = PW'(voice_snap_reg[mul_idx_reg]) *
                      PW'($signed({1'b0, vol_snap_reg[mul_idx_reg]}));
   assign term      = prod_act_reg ? AW'(prod_reg >>> VOL_SHIFT) : '0;
   assign m_full    = (MW'(acc_reg) * MW'($signed({1'b0, master_snap_reg}))) >>> VOL_SHIFT;

`ifdef VOICE_MIXER_SATURATE_EN
   localparam logic signed [MW-1:0] SAT_MAX = {{(MW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [MW-1:0] SAT_MIN = {{(MW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
   logic clip_reg;

   always_comb begin
      out_val  = m_full[SAMPLE_WIDTH-1:0];
      out_clip = 1'b0;
      if (m_full > SAT_MAX) begin
         out_val  = SAT_MAX[SAMPLE_WIDTH-1:0];
         out_clip = 1'b1;
      end else if (m_full < SAT_MIN) begin
         out_val  = SAT_MIN[SAMPLE_WIDTH-1:0];
         out_clip = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         clip_reg <= 1'b0;
      else
         clip_reg <= (state_reg == MASTER) && out_clip;
   end

   assign clip_out = clip_reg;
`else
   assign out_val  = m_full[SAMPLE_WIDTH-1:0];
   assign out_clip = 1'b0;
   assign clip_out = out_clip;
`endif

   // Two-stage MAC: stage 1 registers one product per cycle, stage 2 folds it into acc_reg a cycle later.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg       <= IDLE;
         active_snap_reg <= '0;
         master_snap_reg <= '0;
         mul_idx_reg     <= '0;
         mul_on_reg      <= 1'b0;
         prod_reg        <= '0;
         prod_vld_reg    <= 1'b0;
         prod_act_reg    <= 1'b0;
         prod_last_reg   <= 1'b0;
         acc_reg         <= '0;
         mix_reg         <= '0;
         valid_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (valid_in && busy_reg)
            overrun_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  active_snap_reg <= active_in;
                  master_snap_reg <= master_vol_in;
                  acc_reg         <= '0;
                  mul_idx_reg     <= '0;
                  mul_on_reg      <= 1'b1;
                  prod_vld_reg    <= 1'b0;
                  busy_reg        <= 1'b1;
                  state_reg       <= MAC;
               end
            end
            MAC: begin
               if (mul_on_reg) begin
                  prod_reg      <= prod_next;
                  prod_act_reg  <= active_snap_reg[mul_idx_reg];
                  prod_last_reg <= (mul_idx_reg == IW'(N_VOICES - 1));
                  prod_vld_reg  <= 1'b1;
                  if (mul_idx_reg == IW'(N_VOICES - 1))
                     mul_on_reg <= 1'b0;
                  else
                     mul_idx_reg <= mul_idx_reg + IW'(1);
               end else begin
                  prod_vld_reg <= 1'b0;
               end
               if (prod_vld_reg) begin
                  acc_reg <= acc_reg + term;
                  if (prod_last_reg)
                     state_reg <= MASTER;
               end
            end
            MASTER: begin
               mix_reg   <= out_val;
               valid_reg <= 1'b1;
               state_reg <= OUT;
            end
            OUT: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign mix_out     = mix_reg;
   assign valid_out   = valid_reg;
   assign busy_out    = busy_reg;
   assign overrun_out = overrun_reg;
endmodule

// File: tb/tb_voice_mixer.sv
// Randomized self-checking bench for voice_mixer against an arithmetic reference of the mix rules.
module tb_voice_mixer;
   localparam int N  = 8;
   localparam int SW = 24;
   localparam int VW = 8;
   localparam int SH = 7;
   localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (SW - 1));

   logic            clk;
   logic            rst_n;
   logic            valid_in;
   logic [N*SW-1:0] voices_in;
   logic [N*VW-1:0] vol_in;
   logic [N-1:0]    active_in;
   logic [VW-1:0]   master_vol_in;
   logic [SW-1:0]   mix_out;
   logic            valid_out;
   logic            busy_out;
   logic            clip_out;
   logic            overrun_out;

   int vectors;
   int miscompares;
   int v [N];
   int g [N];
   logic [N-1:0] act;
   int mv;

   voice_mixer #(.N_VOICES(N), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .VOL_SHIFT(SH)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .voices_in(voices_in),
      .vol_in(vol_in), .active_in(active_in), .master_vol_in(master_vol_in),
      .mix_out(mix_out), .valid_out(valid_out), .busy_out(busy_out),
      .clip_out(clip_out), .overrun_out(overrun_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint fdiv(longint a, longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   task automatic model(output logic [SW-1:0] exp_mix, output logic exp_clip);
      longint acc;
      longint m;
      acc = 0;
      for (int i = 0; i < N; i++)
         if (act[i]) acc += fdiv(longint'(v[i]) * longint'(g[i]), 128);
      m = fdiv(acc * longint'(mv), 128);
      exp_mix  = SW'(m);
      exp_clip = 1'b0;
`ifdef VOICE_MIXER_SATURATE_EN
      if (m > SMAX) begin exp_mix = SW'(SMAX); exp_clip = 1'b1; end
      else if (m < SMIN) begin exp_mix = SW'(SMIN); exp_clip = 1'b1; end
`endif
   endtask

   task automatic randomize_all();
      logic [SW-1:0] r;
      for (int i = 0; i < N; i++) begin
         r    = SW'($urandom);
         v[i] = int'($signed(r));
         g[i] = int'($urandom_range(0, 255));
      end
      act = N'($urandom);
      mv  = int'($urandom_range(0, 255));
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         voices_in[i*SW +: SW] = SW'(v[i]);
         vol_in[i*VW +: VW]    = VW'(g[i]);
      end
      active_in     = act;
      master_vol_in = VW'(mv);
   endtask

   task automatic idle_edge();
      @(posedge clk); #1;
   endtask

   // Drives a tick during cycle 0; returns positioned in cycle 1.
   task automatic tick_now();
      drive_inputs();
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   // Called while in cycle 'start'; returns the cycle of the first valid_out (-1 on timeout).
   task automatic wait_out(input int start, output int cyc, output logic [SW-1:0] mix, output logic clip);
      bit found;
      found = 0; cyc = start; mix = '0; clip = 1'b0;
      while (!found && cyc < start + 40) begin
         @(negedge clk);
         if (valid_out) begin
            found = 1; mix = mix_out; clip = clip_out;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!found) cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_in = 1'b0;
      randomize_all(); drive_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (mix_out !== '0) begin miscompares++; $display("FAIL reset_mix got %0d want 0", mix_out); end
      vectors++; if ({valid_out, busy_out, clip_out, overrun_out} !== 4'b0) begin
         miscompares++; $display("FAIL reset_flags got %b want 0000", {valid_out, busy_out, clip_out, overrun_out}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_voice();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc;
      randomize_all();
      v[0] = 1000; g[0] = 128; mv = 128; act = 8'h01;
      model(em, ec);
      idle_edge(); tick_now();
      @(negedge clk);
      vectors++; if (busy_out !== 1'b1 || valid_out !== 1'b0) begin
         miscompares++; $display("FAIL single_cycle1 busy=%b valid=%b want busy=1 valid=0", busy_out, valid_out); end
      @(posedge clk); #1;
      wait_out(2, cyc, gm, gc);
      $display("single: cycle=%0d mix=%0d clip=%b", cyc, $signed(gm), gc);
      vectors++; if (cyc !== N + 3) begin miscompares++; $display("FAIL single_latency got %0d want %0d", cyc, N + 3); end
      vectors++; if (gm !== SW'(1000) || gm !== em) begin miscompares++; $display("FAIL single_mix got %0d want 1000", $signed(gm)); end
      vectors++; if (gc !== 1'b0) begin miscompares++; $display("FAIL single_clip got %b want 0", gc); end
      vectors++; if (busy_out !== 1'b1) begin miscompares++; $display("FAIL single_busy_out_cycle got %b want 1", busy_out); end
      @(posedge clk); @(negedge clk);
      vectors++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
         miscompares++; $display("FAIL single_after valid=%b busy=%b want 0 0", valid_out, busy_out); end
   endtask

   task automatic test_saturation();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc;
      for (int i = 0; i < N; i++) begin v[i] = 1 << 22; g[i] = 128; end
      mv = 128; act = 8'hFF;
      model(em, ec);
      idle_edge(); tick_now();
      wait_out(1, cyc, gm, gc);
      $display("saturation: cycle=%0d mix=%0d clip=%b", cyc, $signed(gm), gc);
      vectors++; if (gm !== em) begin miscompares++; $display("FAIL sat_mix got %0d want %0d", $signed(gm), $signed(em)); end
      vectors++; if (gc !== ec) begin miscompares++; $display("FAIL sat_clip got %b want %b", gc, ec); end
   endtask

   task automatic test_floor();
      logic [SW-1:0] gm; logic gc; int cyc;
      int sv [2];
      int want [2];
      sv[0] = -3; sv[1] = 3; want[0] = -2; want[1] = 1;
      for (int k = 0; k < 2; k++) begin
         randomize_all();
         v[0] = sv[k]; g[0] = 64; mv = 128; act = 8'h01;
         idle_edge(); tick_now();
         wait_out(1, cyc, gm, gc);
         $display("floor: voice0=%0d mix=%0d", sv[k], $signed(gm));
         vectors++; if (gm !== SW'(want[k])) begin
            miscompares++; $display("FAIL floor_%0d got %0d want %0d", sv[k], $signed(gm), want[k]); end
      end
   endtask

   task automatic test_mask_snapshot();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc;
      randomize_all();
      for (int i = 0; i < N; i++) if (v[i] == 0) v[i] = 5;
      act = 8'h00; mv = 200;
      idle_edge(); tick_now();
      wait_out(1, cyc, gm, gc);
      $display("mask: cycle=%0d mix=%0d", cyc, $signed(gm));
      vectors++; if (cyc !== N + 3) begin miscompares++; $display("FAIL mask_valid cycle got %0d want %0d", cyc, N + 3); end
      vectors++; if (gm !== '0) begin miscompares++; $display("FAIL mask_mix got %0d want 0", $signed(gm)); end
      randomize_all(); act = 8'hFF;
      model(em, ec);
      idle_edge(); tick_now();
      randomize_all(); drive_inputs();
      wait_out(1, cyc, gm, gc);
      $display("snapshot: cycle=%0d mix=%0d", cyc, $signed(gm));
      vectors++; if (gm !== em || gc !== ec) begin
         miscompares++; $display("FAIL snapshot_mix got %0d/%b want %0d/%b", $signed(gm), gc, $signed(em), ec); end
   endtask

   task automatic test_overrun();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc;
      vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL overrun_pre got %b want 0", overrun_out); end
      randomize_all(); model(em, ec);
      idle_edge(); tick_now();
      idle_edge(); idle_edge();
      randomize_all(); drive_inputs(); valid_in = 1'b1;
      @(posedge clk); #1; valid_in = 1'b0;
      @(negedge clk);
      vectors++; if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL overrun_set got %b want 1", overrun_out); end
      @(posedge clk); #1;
      wait_out(5, cyc, gm, gc);
      $display("overrun: cycle=%0d mix=%0d", cyc, $signed(gm));
      vectors++; if (cyc !== N + 3) begin miscompares++; $display("FAIL overrun_cycle got %0d want %0d", cyc, N + 3); end
      vectors++; if (gm !== em) begin miscompares++; $display("FAIL overrun_mix got %0d want %0d", $signed(gm), $signed(em)); end
      randomize_all(); model(em, ec);
      idle_edge(); tick_now();
      wait_out(1, cyc, gm, gc);
      $display("overrun_third: cycle=%0d mix=%0d", cyc, $signed(gm));
      vectors++; if (cyc !== N + 3 || gm !== em) begin
         miscompares++; $display("FAIL overrun_third got cyc=%0d mix=%0d want cyc=%0d mix=%0d", cyc, $signed(gm), N + 3, $signed(em)); end
      vectors++; if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky got %b want 1", overrun_out); end
   endtask

   task automatic test_reset_mid_mix();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc, pulses;
      randomize_all();
      idle_edge(); tick_now();
      repeat (4) idle_edge();
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({mix_out, valid_out, busy_out, clip_out, overrun_out} !== '0) begin
         miscompares++; $display("FAIL midreset_async mix=%0d flags=%b want all 0", mix_out,
                                 {valid_out, busy_out, clip_out, overrun_out}); end
      @(posedge clk); #1; rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk); if (valid_out) pulses++;
      end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midreset_no_valid got %0d pulses want 0", pulses); end
      randomize_all(); model(em, ec);
      idle_edge(); tick_now();
      wait_out(1, cyc, gm, gc);
      $display("after_reset: cycle=%0d mix=%0d", cyc, $signed(gm));
      vectors++; if (cyc !== N + 3 || gm !== em || gc !== ec) begin
         miscompares++; $display("FAIL midreset_next got cyc=%0d mix=%0d want cyc=%0d mix=%0d", cyc, $signed(gm), N + 3, $signed(em)); end
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] em, gm; logic ec, gc; int cyc;
      idle_edge();
      for (int t = 0; t < 20; t++) begin
         randomize_all(); model(em, ec);
         tick_now();
         wait_out(1, cyc, gm, gc);
         $display("b2b %0d: cycle=%0d mix=%0d clip=%b", t, cyc, $signed(gm), gc);
         vectors++; if (cyc !== N + 3 || gm !== em || gc !== ec) begin
            miscompares++; $display("FAIL b2b_%0d got cyc=%0d mix=%0d clip=%b want cyc=%0d mix=%0d clip=%b",
                                    t, cyc, $signed(gm), gc, N + 3, $signed(em), ec); end
         @(posedge clk); #1;
      end
      vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", overrun_out); end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      valid_in = 1'b0; rst_n = 1'b0;
      voices_in = '0; vol_in = '0; active_in = '0; master_vol_in = '0;
      test_reset();
      test_single_voice();
      test_saturation();
      test_floor();
      test_mask_snapshot();
      test_overrun();
      test_reset_mid_mix();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
